// File: rtl/snn_param_memory.sv
// Parameter store for the SNN core: M x N register file with burst loader,
// random-access write/read port and a flattened all-entries output bus.
module snn_param_memory #(
  parameter  int M = 162,
  parameter  int N = 8,
  localparam int A = $clog2(M)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           lock_i,
  input  logic           load_start_i,
  input  logic           load_valid_i,
  input  logic [N-1:0]   load_data_i,
  input  logic           wr_en_i,
  input  logic [A-1:0]   wr_addr_i,
  input  logic [N-1:0]   wr_data_i,
  input  logic           rd_en_i,
  input  logic [A-1:0]   rd_addr_i,
  output logic [N-1:0]   rd_data_o,
  output logic           rd_valid_o,
  output logic [M*N-1:0] all_data_out_o,
  output logic           load_busy_o,
  output logic           load_done_o,
  output logic [A-1:0]   load_ptr_o,
  output logic           overflow_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_e;

  localparam logic [A:0]   MA   = (A+1)'(M);
  localparam logic [A-1:0] LAST = A'(M - 1);

  state_e                  state_q, state_d;
  logic [M-1:0][N-1:0]     mem_q, mem_d;
  logic [A-1:0]            ptr_q, ptr_d;
  logic                    ovf_q, ovf_d;
  logic [N-1:0]            rd_data_q, rd_data_d;
  logic                    rd_valid_q;
  logic                    wr_ok;
  logic                    rd_ok;

  assign wr_ok = ({1'b0, wr_addr_i} < MA);
  assign rd_ok = ({1'b0, rd_addr_i} < MA);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ovf_d     = ovf_q;
    mem_d     = mem_q;
    rd_data_d = rd_data_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (load_start_i) begin
          state_d = S_LOAD;
          ptr_d   = '0;
        end
        if (load_valid_i) ovf_d = 1'b1;
      end
      S_LOAD: begin
        // a restart drops any word presented in the same cycle
        if (load_start_i) begin
          ptr_d = '0;
        end else if (load_valid_i && !lock_i) begin
          mem_d[ptr_q] = load_data_i;
          if (ptr_q == LAST) begin
            state_d = S_DONE;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + A'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (wr_en_i && !lock_i && state_q != S_LOAD && wr_ok)
      mem_d[wr_addr_i] = wr_data_i;
    // reads see the pre-edge contents, so same-cycle writes return old data
    if (rd_en_i)
      rd_data_d = rd_ok ? mem_q[rd_addr_i] : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      mem_q      <= '0;
      ptr_q      <= '0;
      ovf_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      ptr_q      <= ptr_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en_i;
    end
  end

  assign all_data_out_o = mem_q;
  assign rd_data_o      = rd_data_q;
  assign rd_valid_o     = rd_valid_q;
  assign load_busy_o    = (state_q == S_LOAD);
  assign load_done_o    = (state_q == S_DONE);
  assign load_ptr_o     = ptr_q;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_snn_param_memory.sv
// Directed bench for snn_param_memory: default 162x8 instance plus
// a 4x16 instance for the parameter sweep.
module tb_snn_param_memory;

  logic          clk;
  logic          rst_n;
  logic          lock;
  logic          ld_start;
  logic          ld_valid;
  logic [7:0]    ld_data;
  logic          wr_en;
  logic [7:0]    wr_addr;
  logic [7:0]    wr_data;
  logic          rd_en;
  logic [7:0]    rd_addr;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [1295:0] all_data;
  logic          busy;
  logic          done;
  logic [7:0]    ptr;
  logic          ovf;

  logic          s_start;
  logic          s_valid;
  logic [15:0]   s_data;
  logic [15:0]   s_rd_data;
  logic          s_rd_valid;
  logic [63:0]   s_all;
  logic          s_busy;
  logic          s_done;
  logic [1:0]    s_ptr;
  logic          s_ovf;

  int checks = 0;
  int failures = 0;

  logic [1295:0] snap;

  snn_param_memory #(.M(162), .N(8)) u_dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .lock_i         (lock),
    .load_start_i   (ld_start),
    .load_valid_i   (ld_valid),
    .load_data_i    (ld_data),
    .wr_en_i        (wr_en),
    .wr_addr_i      (wr_addr),
    .wr_data_i      (wr_data),
    .rd_en_i        (rd_en),
    .rd_addr_i      (rd_addr),
    .rd_data_o      (rd_data),
    .rd_valid_o     (rd_valid),
    .all_data_out_o (all_data),
    .load_busy_o    (busy),
    .load_done_o    (done),
    .load_ptr_o     (ptr),
    .overflow_o     (ovf)
  );

  snn_param_memory #(.M(4), .N(16)) u_small (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .lock_i         (1'b0),
    .load_start_i   (s_start),
    .load_valid_i   (s_valid),
    .load_data_i    (s_data),
    .wr_en_i        (1'b0),
    .wr_addr_i      (2'b00),
    .wr_data_i      (16'h0000),
    .rd_en_i        (1'b0),
    .rd_addr_i      (2'b00),
    .rd_data_o      (s_rd_data),
    .rd_valid_o     (s_rd_valid),
    .all_data_out_o (s_all),
    .load_busy_o    (s_busy),
    .load_done_o    (s_done),
    .load_ptr_o     (s_ptr),
    .overflow_o     (s_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ent(int j);
    return all_data[j*8 +: 8];
  endfunction

  task automatic idle_inputs();
    lock = 0; ld_start = 0; ld_valid = 0; ld_data = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0; rd_en = 0; rd_addr = 0;
    s_start = 0; s_valid = 0; s_data = 0;
  endtask

  task automatic async_reset();
    #3 rst_n = 0;
    #1;
    rst_n = 0;
    #2 rst_n = 1;
    step();
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    step();
    wr_en = 0;
  endtask

  task automatic test_reset();
    checks++;
    if (all_data !== '0 || rd_valid !== 0 || ptr !== 0 || busy !== 0 || done !== 0) begin
      failures++;
      $display("FAIL reset_init: all_nz=%0b rdv=%0b ptr=%0d busy=%0b done=%0b",
               |all_data, rd_valid, ptr, busy, done);
    end
    wr(8'd0, 8'hA5);
    wr(8'd7, 8'hA5);
    wr(8'd161, 8'hA5);
    checks++;
    if (ent(0) !== 8'hA5 || ent(7) !== 8'hA5 || ent(161) !== 8'hA5 || ent(1) !== 8'h00) begin
      failures++;
      $display("FAIL reset_prefill: e0=%h e7=%h e161=%h e1=%h exp a5 a5 a5 00",
               ent(0), ent(7), ent(161), ent(1));
    end
    rd_en = 1; rd_addr = 8'd7; ld_valid = 1;
    step();
    rd_en = 0; ld_valid = 0;
    checks++;
    if (ovf !== 1'b1 || rd_data !== 8'hA5) begin
      failures++;
      $display("FAIL reset_preovf: ovf=%0b rd=%h exp 1 a5", ovf, rd_data);
    end
    #3 rst_n = 0;
    #1;
    checks++;
    if (all_data !== '0 || rd_data !== 0 || ovf !== 0 || busy !== 0 || done !== 0 || rd_valid !== 0) begin
      failures++;
      $display("FAIL reset_async: all_nz=%0b rd=%h ovf=%0b busy=%0b done=%0b rdv=%0b",
               |all_data, rd_data, ovf, busy, done, rd_valid);
    end
    #2 rst_n = 1;
    step();
  endtask

  task automatic test_full_burst();
    int bad;
    ld_start = 1;
    step();
    ld_start = 0;
    checks++;
    if (busy !== 1 || ptr !== 0) begin
      failures++;
      $display("FAIL burst_start: busy=%0b ptr=%0d exp 1 0", busy, ptr);
    end
    for (int j = 0; j < 162; j++) begin
      ld_valid = 1; ld_data = 8'(j);
      step();
      if (j == 0) begin
        checks++;
        if (ptr !== 8'd1 || ent(0) !== 8'd0) begin
          failures++;
          $display("FAIL burst_first: ptr=%0d exp 1", ptr);
        end
      end
      if (j == 160) begin
        checks++;
        if (done !== 0 || busy !== 1 || ptr !== 8'd161) begin
          failures++;
          $display("FAIL burst_pre_last: done=%0b busy=%0b ptr=%0d exp 0 1 161", done, busy, ptr);
        end
      end
    end
    ld_valid = 0;
    checks++;
    if (done !== 1 || busy !== 0 || ptr !== 0) begin
      failures++;
      $display("FAIL burst_done: done=%0b busy=%0b ptr=%0d exp 1 0 0", done, busy, ptr);
    end
    bad = 0;
    for (int j = 0; j < 162; j++)
      if (ent(j) !== 8'(j)) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL burst_contents: bad_entries=%0d exp 0", bad);
    end
    snap = all_data;
    ld_valid = 1; ld_data = 8'hEE;
    step();
    ld_valid = 0;
    checks++;
    if (ovf !== 1 || all_data !== snap || done !== 1) begin
      failures++;
      $display("FAIL burst_overflow: ovf=%0b changed=%0b done=%0b exp 1 0 1",
               ovf, all_data !== snap, done);
    end
  endtask

  task automatic test_lock_restart();
    ld_start = 1;
    step();
    ld_start = 0;
    for (int j = 0; j < 6; j++) begin
      lock = (j >= 3);
      ld_valid = 1; ld_data = (j >= 3) ? 8'hEE : 8'(8'h40 + j);
      step();
    end
    ld_valid = 0; lock = 0;
    checks++;
    if (ptr !== 8'd3 || ent(2) !== 8'h42 || ent(3) !== 8'd3 || busy !== 1) begin
      failures++;
      $display("FAIL lock_stall: ptr=%0d e2=%h e3=%h busy=%0b exp 3 42 03 1",
               ptr, ent(2), ent(3), busy);
    end
    ld_start = 1; ld_valid = 1; ld_data = 8'hFF;
    step();
    ld_start = 0; ld_valid = 0;
    checks++;
    if (ptr !== 0 || busy !== 1 || ent(0) !== 8'h40 || ent(3) !== 8'd3) begin
      failures++;
      $display("FAIL restart: ptr=%0d busy=%0b e0=%h e3=%h exp 0 1 40 03",
               ptr, busy, ent(0), ent(3));
    end
    wr(8'd20, 8'h99);
    checks++;
    if (ent(20) !== 8'd20) begin
      failures++;
      $display("FAIL wr_in_load: e20=%h exp 14", ent(20));
    end
    async_reset();
    checks++;
    if (busy !== 0 || done !== 0 || all_data !== '0) begin
      failures++;
      $display("FAIL midburst_reset: busy=%0b done=%0b all_nz=%0b", busy, done, |all_data);
    end
  endtask

  task automatic test_random();
    wr(8'd10, 8'h3C);
    rd_en = 1; rd_addr = 8'd10;
    step();
    checks++;
    if (rd_data !== 8'h3C || rd_valid !== 1) begin
      failures++;
      $display("FAIL rd_basic: rd=%h rdv=%0b exp 3c 1", rd_data, rd_valid);
    end
    wr_en = 1; wr_addr = 8'd10; wr_data = 8'h77;
    step();
    wr_en = 0;
    checks++;
    if (rd_data !== 8'h3C || ent(10) !== 8'h77) begin
      failures++;
      $display("FAIL rd_same_cycle: rd=%h e10=%h exp 3c 77", rd_data, ent(10));
    end
    step();
    rd_en = 0;
    checks++;
    if (rd_data !== 8'h77) begin
      failures++;
      $display("FAIL rd_after_wr: rd=%h exp 77", rd_data);
    end
    step();
    checks++;
    if (rd_valid !== 0 || rd_data !== 8'h77) begin
      failures++;
      $display("FAIL rd_hold: rdv=%0b rd=%h exp 0 77", rd_valid, rd_data);
    end
  endtask

  task automatic test_guards();
    snap = all_data;
    wr(8'd200, 8'h55);
    checks++;
    if (all_data !== snap) begin
      failures++;
      $display("FAIL wr_oob: storage changed, exp unchanged");
    end
    rd_en = 1; rd_addr = 8'd200;
    step();
    rd_en = 0;
    checks++;
    if (rd_data !== 8'h00 || rd_valid !== 1) begin
      failures++;
      $display("FAIL rd_oob: rd=%h rdv=%0b exp 00 1", rd_data, rd_valid);
    end
    lock = 1;
    wr(8'd11, 8'h66);
    lock = 0;
    checks++;
    if (ent(11) !== 8'h00 || ent(10) !== 8'h77) begin
      failures++;
      $display("FAIL wr_locked: e11=%h e10=%h exp 00 77", ent(11), ent(10));
    end
  endtask

  task automatic test_param_sweep();
    logic [15:0] words [4];
    words[0] = 16'h1234; words[1] = 16'h5678;
    words[2] = 16'h9ABC; words[3] = 16'hDEF0;
    s_start = 1;
    step();
    s_start = 0;
    for (int j = 0; j < 4; j++) begin
      s_valid = 1; s_data = words[j];
      step();
    end
    s_valid = 0;
    checks++;
    if (s_all !== 64'hDEF09ABC56781234 || s_done !== 1 || s_ptr !== 0) begin
      failures++;
      $display("FAIL sweep: all=%h done=%0b ptr=%0d exp def09abc56781234 1 0",
               s_all, s_done, s_ptr);
    end
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    repeat (2) step();
    rst_n = 1;
    step();
    test_reset();
    test_full_burst();
    test_lock_restart();
    test_random();
    test_guards();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
